// File: rtl/memoria_pkg.sv
// Shared definitions for the wait-state memory: FSM states, parameter
// defaults and the power-up program image.
package memoria_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  localparam int LARGURA_PADRAO      = 16;
  localparam int PROFUNDIDADE_PADRAO = 64;
  localparam int LARGURA_END_PADRAO  = 16;
  localparam int LATENCIA_PADRAO     = 2;
  localparam int LATENCIA_MAX        = 15;

  // Power-up image: word i holds IMAGEM_BASE + i, truncated to the word width.
  localparam logic [31:0] IMAGEM_BASE = 32'h0000_A500;

  function automatic logic [31:0] palavra_imagem(input int unsigned i);
    return IMAGEM_BASE + 32'(i);
  endfunction

endpackage

// File: rtl/memoria_ws_if.sv
// Request/response bus between the processor datapath (master) and the
// wait-state memory (slave).
interface memoria_ws_if #(
  parameter int LARGURA     = 16,
  parameter int LARGURA_END = 16
);
  // Handshake: the master raises pedido with escrever/endereco/din; the slave
  // samples it on a rising edge only while ocupado=0 (or in its final cycle),
  // then answers with a one-cycle pronto, erro qualifying it and dout valid.
  logic                   pedido;
  logic                   escrever;
  logic [LARGURA_END-1:0] endereco;
  logic [LARGURA-1:0]     din;
  logic [LARGURA-1:0]     dout;
  logic                   pronto;
  logic                   erro;
  logic                   ocupado;

  modport master (
    output pedido, escrever, endereco, din,
    input  dout, pronto, erro, ocupado
  );

  modport slave (
    input  pedido, escrever, endereco, din,
    output dout, pronto, erro, ocupado
  );
endinterface

// File: rtl/memoria_nucleo.sv
// Storage array: one register per word with synchronous write, asynchronous
// read, and each word powering up with its program image value.
module memoria_nucleo
  import memoria_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  localparam int LARGURA_IDX = $clog2(PROFUNDIDADE)
) (
  input  logic                   clock,
  input  logic                   we_i,
  input  logic [LARGURA_IDX-1:0] addr_i,
  input  logic [LARGURA-1:0]     wdata_i,
  output logic [LARGURA-1:0]     rdata_o
);

  logic [PROFUNDIDADE-1:0][LARGURA-1:0] palavras;

  for (genvar g = 0; g < PROFUNDIDADE; g++) begin : g_pal
    logic [LARGURA-1:0] pal_q = LARGURA'(palavra_imagem(g));

    always_ff @(posedge clock) begin
      if (we_i && (addr_i == LARGURA_IDX'(g))) begin
        pal_q <= wdata_i;
      end
    end

    assign palavras[g] = pal_q;
  end

  assign rdata_o = palavras[addr_i];

endmodule

// File: rtl/memoria_ws.sv
// Parametrised memory with configurable wait states, request/ready handshake
// and out-of-range flagging in place of address aliasing.
module memoria_ws
  import memoria_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LARGURA_END  = LARGURA_END_PADRAO,
  parameter int LATENCIA     = LATENCIA_PADRAO
) (
  input  logic         clock,
  input  logic         reset,
  memoria_ws_if.slave  bus,
  output estado_t      estado_o
);

  localparam int LARGURA_CONT = (LATENCIA > 0) ? $clog2(LATENCIA + 1) : 1;
  localparam int LARGURA_IDX  = $clog2(PROFUNDIDADE);
  localparam logic [LARGURA_CONT-1:0] CARGA = LARGURA_CONT'(LATENCIA);

  if (LATENCIA < 0 || LATENCIA > LATENCIA_MAX) begin : g_latencia_invalida
    $error("memoria_ws: LATENCIA fora da faixa 0..15");
  end
  if (PROFUNDIDADE < 2 || PROFUNDIDADE > (2 ** LARGURA_END)) begin : g_profundidade_invalida
    $error("memoria_ws: PROFUNDIDADE fora da faixa 2..2^LARGURA_END");
  end

  estado_t                 estado_q;
  logic [LARGURA_CONT-1:0] cont_q;
  logic                    escrever_q;
  logic [LARGURA_END-1:0]  endereco_q;
  logic [LARGURA-1:0]      din_q;
  logic [LARGURA-1:0]      dout_q;
  logic                    pronto_q;
  logic                    erro_q;
  logic                    ocupado_q;

  logic                    fora;
  logic                    commit;
  logic                    we;
  logic [LARGURA-1:0]      rdata;

  // One extra bit so PROFUNDIDADE = 2^LARGURA_END does not wrap to zero.
  assign fora   = {1'b0, endereco_q} >= (LARGURA_END + 1)'(PROFUNDIDADE);
  assign commit = (estado_q == ESPERA) && (cont_q == '0);
  assign we     = commit && escrever_q && !fora;

  memoria_nucleo #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_nucleo (
    .clock   (clock),
    .we_i    (we),
    .addr_i  (endereco_q[LARGURA_IDX-1:0]),
    .wdata_i (din_q),
    .rdata_o (rdata)
  );

  // ESPERA lasts LATENCIA+1 cycles, so the commit edge is accept+LATENCIA+1.
  // A request present during CONCLUI is taken on the edge that frees the
  // memory, giving one operation every LATENCIA+2 cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      cont_q     <= '0;
      escrever_q <= 1'b0;
      endereco_q <= '0;
      din_q      <= '0;
      dout_q     <= '0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;
      case (estado_q)
        OCIOSO, CONCLUI: begin
          if (bus.pedido) begin
            estado_q   <= ESPERA;
            cont_q     <= CARGA;
            escrever_q <= bus.escrever;
            endereco_q <= bus.endereco;
            din_q      <= bus.din;
            ocupado_q  <= 1'b1;
          end else begin
            estado_q  <= OCIOSO;
            ocupado_q <= 1'b0;
          end
        end
        ESPERA: begin
          if (cont_q == '0) begin
            estado_q <= CONCLUI;
            pronto_q <= 1'b1;
            erro_q   <= fora;
            if (!escrever_q) begin
              dout_q <= fora ? '0 : rdata;
            end
          end else begin
            cont_q <= cont_q - 1'b1;
          end
        end
        default: begin
          estado_q  <= OCIOSO;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout    = dout_q;
  assign bus.pronto  = pronto_q;
  assign bus.erro    = erro_q;
  assign bus.ocupado = ocupado_q;
  assign estado_o    = estado_q;

endmodule

// File: tb/tb_memoria_ws.sv
// Directed bench for memoria_ws: default, zero-latency and wide/slow instances.
module tb_memoria_ws;
  import memoria_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memoria_ws_if #(.LARGURA(16), .LARGURA_END(16)) a_if ();
  memoria_ws_if #(.LARGURA(16), .LARGURA_END(16)) b_if ();
  memoria_ws_if #(.LARGURA(32), .LARGURA_END(16)) c_if ();
  estado_t a_est, b_est, c_est;

  memoria_ws dut_a (.clock(clk), .reset(rst), .bus(a_if), .estado_o(a_est));

  memoria_ws #(.LATENCIA(0)) dut_b (
    .clock(clk), .reset(rst), .bus(b_if), .estado_o(b_est));

  memoria_ws #(.LARGURA(32), .PROFUNDIDADE(16), .LATENCIA(15)) dut_c (
    .clock(clk), .reset(rst), .bus(c_if), .estado_o(c_est));

  typedef struct packed {
    logic        pronto;
    logic        erro;
    logic        ocupado;
    logic [31:0] dout;
    logic [1:0]  estado;
  } obs_t;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic dirige(input int inst, input logic ped, input logic escr,
                        input logic [15:0] addr, input logic [31:0] dado);
    case (inst)
      0: begin a_if.pedido = ped; a_if.escrever = escr; a_if.endereco = addr; a_if.din = dado[15:0]; end
      1: begin b_if.pedido = ped; b_if.escrever = escr; b_if.endereco = addr; b_if.din = dado[15:0]; end
      default: begin c_if.pedido = ped; c_if.escrever = escr; c_if.endereco = addr; c_if.din = dado; end
    endcase
  endtask

  function automatic obs_t observa(input int inst);
    obs_t o;
    case (inst)
      0: o = '{a_if.pronto, a_if.erro, a_if.ocupado, {16'h0, a_if.dout}, a_est};
      1: o = '{b_if.pronto, b_if.erro, b_if.ocupado, {16'h0, b_if.dout}, b_est};
      default: o = '{c_if.pronto, c_if.erro, c_if.ocupado, c_if.dout, c_est};
    endcase
    return o;
  endfunction

  // One request; lat = edges from accept to the edge raising pronto (-1 on timeout).
  task automatic operacao(input int inst, input logic escr, input logic [15:0] addr,
                          input logic [31:0] dado, output int lat, output logic [31:0] lido,
                          output logic err, output logic ocup_ini, output logic ocup_fim);
    obs_t o;
    lat = -1; lido = 32'hx; err = 1'bx;
    @(negedge clk);
    dirige(inst, 1'b1, escr, addr, dado);
    @(negedge clk);
    dirige(inst, 1'b0, 1'b0, 16'h0, 32'h0);
    o = observa(inst);
    ocup_ini = o.ocupado;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      o = observa(inst);
      if (o.pronto) begin
        lat = k; lido = o.dout; err = o.erro;
        break;
      end
    end
    @(negedge clk);
    o = observa(inst);
    ocup_fim = o.ocupado;
  endtask

  task automatic wr_check(input string tag, input int inst, input logic [15:0] addr,
                          input logic [31:0] dado, input int exp_lat, input logic exp_err);
    int lat; logic [31:0] lido; logic err, oi, of;
    operacao(inst, 1'b1, addr, dado, lat, lido, err, oi, of);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_erro"}, {31'h0, err}, {31'h0, exp_err});
    check({tag, "_ocupado"}, {30'h0, oi, of}, 32'h2);
  endtask

  task automatic rd_check(input string tag, input int inst, input logic [15:0] addr,
                          input int exp_lat, input logic [31:0] exp_dado, input logic exp_err);
    int lat; logic [31:0] lido; logic err, oi, of;
    exp_q.push_back(exp_dado);
    operacao(inst, 1'b0, addr, 32'h0, lat, lido, err, oi, of);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_dout"}, lido, exp_q.pop_front());
    check({tag, "_erro"}, {31'h0, err}, {31'h0, exp_err});
    check({tag, "_ocupado"}, {30'h0, oi, of}, 32'h2);
  endtask

  // ---------------- directed sequence ----------------
  obs_t o;
  int   n_pronto;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) dirige(i, 1'b0, 1'b0, 16'h0, 32'h0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      o = observa(i);
      check($sformatf("rst%0d_saidas", i), {29'h0, o.pronto, o.erro, o.ocupado}, 32'h0);
      check($sformatf("rst%0d_dout", i), o.dout, 32'h0);
      check($sformatf("rst%0d_estado", i), {30'h0, o.estado}, {30'h0, OCIOSO});
    end
    rst = 1'b0;

    // Defaults: write then read back address 5, pronto 3 edges after accept.
    wr_check("a_wr5", 0, 16'd5, 32'h0026, 3, 1'b0);
    rd_check("a_rd5", 0, 16'd5, 3, 32'h0026, 1'b0);

    // Zero latency, pedido held high: accepts two edges apart.
    @(negedge clk);
    dirige(1, 1'b1, 1'b0, 16'd0, 32'h0);
    @(negedge clk);
    dirige(1, 1'b1, 1'b0, 16'd1, 32'h0);
    @(negedge clk);
    o = observa(1);
    check("b_rd0_pronto", {31'h0, o.pronto}, 32'h1);
    check("b_rd0_dout", o.dout, 32'h0000_A500);
    @(negedge clk);
    o = observa(1);
    check("b_aceite2", {30'h0, o.pronto, o.ocupado}, 32'h1);
    dirige(1, 1'b0, 1'b0, 16'd0, 32'h0);
    @(negedge clk);
    o = observa(1);
    check("b_rd1_pronto", {31'h0, o.pronto}, 32'h1);
    check("b_rd1_dout", o.dout, 32'h0000_A501);
    check("b_rd1_erro", {31'h0, o.erro}, 32'h0);
    @(negedge clk);
    o = observa(1);
    check("b_livre", {31'h0, o.ocupado}, 32'h0);

    // Out of range on the default instance.
    wr_check("a_wr64", 0, 16'd64, 32'hFFFF, 3, 1'b1);
    rd_check("a_rd64", 0, 16'd64, 3, 32'h0, 1'b1);
    rd_check("a_rd0", 0, 16'd0, 3, 32'h0000_A500, 1'b0);

    // Busy ignore: a write to 7 pulsed during ESPERA of a read of 7.
    @(negedge clk);
    dirige(0, 1'b1, 1'b0, 16'd7, 32'h0);
    @(negedge clk);
    dirige(0, 1'b1, 1'b1, 16'd7, 32'hBEEF);
    @(negedge clk);
    dirige(0, 1'b0, 1'b0, 16'd0, 32'h0);
    n_pronto = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      o = observa(0);
      if (o.pronto) n_pronto++;
      if (o.pronto) check("a_ocup_rd7_dout", o.dout, 32'h0000_A507);
    end
    check("a_ocup_pronto_cnt", 32'(n_pronto), 32'd1);
    rd_check("a_rd7", 0, 16'd7, 3, 32'h0000_A507, 1'b0);

    // Reset in ESPERA aborts a write of 1234 to address 3.
    @(negedge clk);
    dirige(0, 1'b1, 1'b1, 16'd3, 32'h1234);
    @(negedge clk);
    dirige(0, 1'b0, 1'b0, 16'd0, 32'h0);
    o = observa(0);
    check("a_rst_pre_estado", {30'h0, o.estado}, {30'h0, ESPERA});
    rst = 1'b1;
    #1;
    o = observa(0);
    check("a_rst_saidas", {29'h0, o.pronto, o.erro, o.ocupado}, 32'h0);
    check("a_rst_dout", o.dout, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_pronto = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      o = observa(0);
      if (o.pronto) n_pronto++;
    end
    check("a_rst_sem_pronto", 32'(n_pronto), 32'd0);
    rd_check("a_rd3", 0, 16'd3, 3, 32'h0000_A503, 1'b0);

    // Wide, slow instance: 32-bit words, 16 deep, 15 wait states.
    wr_check("c_wr15", 2, 16'd15, 32'hDEADBEEF, 16, 1'b0);
    rd_check("c_rd15", 2, 16'd15, 16, 32'hDEADBEEF, 1'b0);
    rd_check("c_rd16", 2, 16'd16, 16, 32'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
